// File: rtl/i2c_rx_regwr.sv
// i2c_rx_regwr
// Register-write front end for an I2C slave. Sits behind a byte receiver and
// turns a write transaction (START, address+W, pointer, data...) into
// register write strobes, auto-incrementing the pointer per data byte.
//
// State table:
//   IDLE   | bus idle, waiting for START; rx=1, ack=1
//   ADDR   | expecting the address byte
//   PTR    | expecting the register pointer byte
//   DATA   | each byte is written to regs[ptr], then ptr advances
//   IGNORE | transaction rejected; bytes NACKed until START/STOP
//
// Ports:
//   clk, rst          clock and async active-high reset
//   start, stop       one-cycle bus condition pulses
//   data, data_rdy    received byte and its active-low ready (held for ack phase)
//   ack_en            active-low ack sampling indicator from the receiver
//   ack               0 = ACK, 1 = NACK for the current byte
//   rx                active-low receive enable to the byte receiver
//   wr_en, wr_addr, wr_data  one-cycle register write strobe with index/data
//   busy              high whenever not IDLE
//   err               sticky pointer-overrun flag, cleared on START
module i2c_rx_regwr #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NUM_REGS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] data,
    input  logic       data_rdy,
    input  logic       ack_en,
    output logic       ack,
    output logic       rx,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_PTR    = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_IGNORE = 3'd4;

    // Nine bits so that NUM_REGS = 256 compares correctly against 8-bit values.
    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

    logic [2:0] state;
    logic [7:0] ptr;
    logic       rdy_q;
    logic       byte_evt;

    // ack is held registered across the whole ack phase, so the receiver's
    // sampling strobe carries no information this block needs.
    logic       ack_en_unused;
    assign ack_en_unused = ack_en;

    // One event per byte: first cycle data_rdy is seen low after being high.
    assign byte_evt = rdy_q & ~data_rdy;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b1;
        end else begin
            rdy_q <= data_rdy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= 8'h00;
            ack     <= 1'b1;
            rx      <= 1'b1;
            wr_en   <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
            err     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                state <= S_ADDR;
                rx    <= 1'b0;
                err   <= 1'b0;
                ack   <= 1'b1;
            end else if (stop) begin
                state <= S_IDLE;
                rx    <= 1'b1;
                ack   <= 1'b1;
            end else if (byte_evt) begin
                case (state)
                    S_ADDR: begin
                        if (data[7:1] == DEV_ADDR && !data[0]) begin
                            ack   <= 1'b0;
                            state <= S_PTR;
                        end else begin
                            ack   <= 1'b1;
                            rx    <= 1'b1;
                            state <= S_IGNORE;
                        end
                    end
                    S_PTR: begin
                        ptr <= data;
                        if ({1'b0, data} >= NUM_REGS_W) begin
                            ack   <= 1'b1;
                            err   <= 1'b1;
                            rx    <= 1'b1;
                            state <= S_IGNORE;
                        end else begin
                            ack   <= 1'b0;
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        // Overrun is judged on the current pointer before any wrap.
                        if ({1'b0, ptr} >= NUM_REGS_W) begin
                            ack   <= 1'b1;
                            err   <= 1'b1;
                            rx    <= 1'b1;
                            state <= S_IGNORE;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= ptr;
                            wr_data <= data;
                            ptr     <= ptr + 8'd1;
                            ack     <= 1'b0;
                        end
                    end
                    default: begin
                        ack <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_rx_regwr.md
I2C_RX_REGWR -- requirements
Module: i2c_rx_regwr

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42, the 7-bit device address that this block acknowledges.
REQ-002 SHALL have parameter NUM_REGS, default 16, the number of writable registers (1..256).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high; one clock, no other clock domain.
REQ-005 start  input  1  one-cycle pulse on a bus START or repeated START condition.
REQ-006 stop  input  1  one-cycle pulse on a bus STOP condition.
REQ-007 data  input  8  received byte from the upstream byte receiver; MSB first on the wire.
REQ-008 data_rdy  input  1  active-low; held low by the receiver for the whole ack phase of one byte.
REQ-009 ack_en  input  1  active-low; indicates the receiver is sampling ack.
REQ-010 ack  output  1  0 = ACK, 1 = NACK for the current byte.
REQ-011 rx  output  1  active-low receive enable to the byte receiver.
REQ-012 wr_en  output  1  one-cycle register write strobe.
REQ-013 wr_addr  output  8  register index for the write.
REQ-014 wr_data  output  8  register write data.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 err  output  1  sticky flag set on a pointer overrun; cleared on the next START.

Function
REQ-017 SHALL detect a byte event on the first clk cycle in which data_rdy is low after it was high (registered edge detect), giving one event per byte.
REQ-018 SHALL implement states IDLE, ADDR, PTR, DATA and IGNORE.
REQ-019 IDLE: rx=1 and ack=1; on start -> ADDR with rx=0.
REQ-020 ADDR byte event: if data[7:1]==DEV_ADDR and data[0]==0 -> ack=0 and go to PTR; otherwise -> ack=1, rx=1 and go to IGNORE.
REQ-021 PTR byte event: ptr<=data, ack=0, go to DATA; if data>=NUM_REGS -> ack=1, err=1 and go to IGNORE.
REQ-022 DATA byte event: wr_en=1 for exactly one cycle, the cycle after the event, with wr_addr=ptr and wr_data=data; ptr<=ptr+1; ack=0.
REQ-023 DATA byte event with ptr>=NUM_REGS (auto-increment overrun): no write, ack=1, err=1, rx=1 and go to IGNORE.
REQ-024 ptr arithmetic SHALL be 8-bit; 8'hFF+1 wraps to 8'h00, and the overrun check in REQ-023 applies first.
REQ-025 IGNORE: byte events are ignored and ack stays 1; only start or stop leave this state.
REQ-026 ack SHALL be registered, update in the cycle after the byte event, and hold its value until the next byte event, start or stop, so it is stable for the whole time ack_en is low.
REQ-027 stop in any state SHALL go to IDLE with rx=1 and ack=1.
REQ-028 start in any state SHALL go to ADDR with rx=0, err=0 and ack=1 (repeated START is supported).
REQ-029 Same-cycle priority SHALL be start > stop > byte event; a byte event coinciding with start or stop produces no write and no ack change.
REQ-030 wr_en SHALL never be asserted outside the DATA state.
REQ-031 Writes SHALL happen at most once per byte, even while data_rdy stays low for many cycles.

Reset
REQ-032 While rst=1 (asynchronous), outputs SHALL be: state=IDLE, ack=1, rx=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, err=0; internally ptr=0 and the data_rdy edge-detect register=1.
REQ-033 rst asserted mid-transfer SHALL abort it immediately with no partial write; after release the block waits for a fresh start.

Verification
REQ-034 start; bytes 8'h84, 8'h03, 8'hAA, 8'h55; stop -> ACK on all four bytes; writes (3,AA) then (4,55); busy falls after stop.
REQ-035 start; byte 8'h86 (wrong address) -> ack=1 and rx=1; following bytes produce no wr_en; state IGNORE until stop.
REQ-036 start; 8'h84, 8'h0F, 8'h11, 8'h22 with NUM_REGS=16 -> write (15,11); 4th byte NACKed, no write, err=1.
REQ-037 start; 8'h84, 8'h02, 8'h01; repeated start; 8'h84, 8'h07, 8'h09 -> writes (2,01) then (7,09); err=0.
REQ-038 data_rdy held low for 200 cycles on a DATA byte -> exactly one wr_en pulse; ack=0 stable while ack_en is low.
REQ-039 rst pulse during the DATA state -> all outputs return to the REQ-032 values within the same cycle; bytes after reset are ignored until start.
